pipe_hazard_sched: RTL

Sequential interlock scheduler for the 5-stage pipeline. It sits beside the decode-stage control unit and produces the PC/IR write enable, the E-stage bubble request and the fetch-slot flush. It resolves three cases:
- load-use hazards (one-cycle stall);
- a shared multi-cycle multiply/divide unit (MDU), which it sequences with a busy counter and stalls dependent instructions against;
- optional taken-branch squash.

---
 rtl/pipe_hazard_sched_if.sv | 40 ++++
 rtl/pipe_hazard_sched.sv | 113 +++++++++++
 2 files changed

// File: rtl/pipe_hazard_sched_if.sv
// Decode/E-stage hazard inputs and pipeline-control outputs shared between
// the decode-stage control unit (master) and the interlock scheduler (slave).
interface pipe_hazard_sched_if #(
  parameter int CNT_W = 16
) ();
  logic             d_valid;
  logic [4:0]       d_rs;
  logic [4:0]       d_rt;
  logic             d_use_rs;
  logic             d_use_rt;
  logic             d_is_md;
  logic             d_md_div;
  logic             d_rd_hilo;
  logic [4:0]       ern;
  logic             ewreg;
  logic             em2reg;
  logic             branch_taken;
  logic             wpcir;
  logic             bubble;
  logic             flush_d;
  logic             md_start;
  logic             md_div;
  logic             md_busy;
  logic             md_done;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output d_valid, d_rs, d_rt, d_use_rs, d_use_rt, d_is_md, d_md_div,
           d_rd_hilo, ern, ewreg, em2reg, branch_taken,
    input  wpcir, bubble, flush_d, md_start, md_div, md_busy, md_done,
           stall_cnt
  );

  modport slave (
    input  d_valid, d_rs, d_rt, d_use_rs, d_use_rt, d_is_md, d_md_div,
           d_rd_hilo, ern, ewreg, em2reg, branch_taken,
    output wpcir, bubble, flush_d, md_start, md_div, md_busy, md_done,
           stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_sched.sv
// Interlock scheduler for the 5-stage pipeline: load-use stalls, sequencing of
// the shared multi-cycle MDU, and optional squash of the fetch slot on taken branches.
module pipe_hazard_sched #(
  parameter int MULT_CYCLES   = 4,
  parameter int DIV_CYCLES    = 32,
  parameter int BR_DELAY_SLOT = 1,
  parameter int CNT_W         = 16
) (
  input logic               clock,
  input logic               resetn,
  pipe_hazard_sched_if.slave hz
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES - 1);
  localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES - 1);
  localparam logic       SQUASH_EN = (BR_DELAY_SLOT == 0);

  state_t           state_q, state_d;
  logic [5:0]       md_cnt_q, md_cnt_d;
  logic             md_div_q, md_div_d;
  logic [CNT_W-1:0] stall_cnt_q;

  logic rs_hit, rt_hit, lu_haz, md_haz, stall, issue;
  logic wpcir, bubble, flush_d, md_start, md_div, md_busy, md_done;

  always_comb begin
    rs_hit = hz.d_use_rs && (hz.ern == hz.d_rs);
    rt_hit = hz.d_use_rt && (hz.ern == hz.d_rt);
    lu_haz = hz.d_valid && hz.ewreg && hz.em2reg && (hz.ern != 5'd0)
             && (rs_hit || rt_hit);
    md_haz = hz.d_valid && (state_q == BUSY) && (hz.d_is_md || hz.d_rd_hilo);
    stall  = lu_haz || md_haz;
    // Load-use wins over issue: the md instruction launches once the load clears.
    issue  = hz.d_valid && hz.d_is_md && (state_q == IDLE) && !lu_haz;
  end

  always_comb begin
    wpcir    = 1'b1;
    bubble   = 1'b0;
    flush_d  = 1'b0;
    md_start = 1'b0;
    md_busy  = 1'b0;
    md_done  = 1'b0;
    md_div   = hz.d_md_div;
    if (resetn) begin
      wpcir    = !stall;
      bubble   = stall;
      flush_d  = SQUASH_EN && hz.d_valid && hz.branch_taken && !stall;
      md_start = issue;
      md_busy  = (state_q == BUSY);
      md_done  = (state_q == BUSY) && (md_cnt_q == 6'd0);
      md_div   = (state_q == BUSY) ? md_div_q : hz.d_md_div;
    end
  end

  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    md_div_d = md_div_q;
    case (state_q)
      IDLE: begin
        if (issue) begin
          state_d  = BUSY;
          md_cnt_d = hz.d_md_div ? DIV_LOAD : MULT_LOAD;
          md_div_d = hz.d_md_div;
        end
      end
      BUSY: begin
        if (md_cnt_q == 6'd0) begin
          state_d = IDLE;
        end else begin
          md_cnt_d = md_cnt_q - 6'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= IDLE;
      md_cnt_q <= 6'd0;
      md_div_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
      md_div_q <= md_div_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      stall_cnt_q <= '0;
    end else if (!wpcir && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign hz.wpcir     = wpcir;
  assign hz.bubble    = bubble;
  assign hz.flush_d   = flush_d;
  assign hz.md_start  = md_start;
  assign hz.md_div    = md_div;
  assign hz.md_busy   = md_busy;
  assign hz.md_done   = md_done;
  assign hz.stall_cnt = stall_cnt_q;

endmodule
